// File: rtl/bus_sram_pkg.sv
// Shared types and constants for the bus-to-async-SRAM controller.
package bus_sram_pkg;

    typedef enum logic [2:0] {IDLE, LO, HI, DONE, RECOV} state_t;

    localparam logic [3:0] SEL_LO_MASK = 4'b0011;
    localparam logic [3:0] SEL_HI_MASK = 4'b1100;
    localparam int         MIN_WAIT    = 2;

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter that times one halfword phase and flags its last cycle and strobe window.
module sram_phase_timer
    import bus_sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last,
    output logic we_win
);

    localparam int WAIT_EFF = (WAIT_CYCLES < MIN_WAIT) ? MIN_WAIT : WAIT_CYCLES;
    localparam int CNT_W    = $clog2(WAIT_EFF + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(WAIT_EFF);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));
    // Pins are registered, so the window looks one cycle ahead: strobe stays low next cycle.
    assign we_win = (cnt > CNT_W'(2));

endmodule

// File: rtl/wb_sram_ctrl.sv
// Bus slave that splits each 32-bit access into timed halfword phases on a 16-bit async SRAM.
module wb_sram_ctrl
    import bus_sram_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    input  logic [3:0]        sel_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
);

    state_t            state;
    logic [ADDR_W-2:0] adr_q;
    logic [31:0]       dat_q;
    logic [3:0]        sel_q;
    logic              we_q;

    logic              accept, start_lo, start_hi, load, last, we_win, in_phase;
    logic [ADDR_W-2:0] src_adr;
    logic [31:0]       src_dat;
    logic [3:0]        src_sel;
    logic              src_we;
    logic [1:0]        ph_sel;
    logic [15:0]       ph_dat;
    logic              unused_adr;

    function automatic logic [15:0] lane_mask(input logic [1:0] s);
        return {{8{s[1]}}, {8{s[0]}}};
    endfunction

    assign accept   = (state == IDLE) && stb_i;
    assign start_lo = accept && (|(sel_i & SEL_LO_MASK));
    assign start_hi = (accept && !(|(sel_i & SEL_LO_MASK)) && (|(sel_i & SEL_HI_MASK)))
                   || ((state == LO) && last && (|(sel_q & SEL_HI_MASK)));
    assign load     = start_lo | start_hi;
    assign in_phase = (state == LO) || (state == HI);

    assign unused_adr = ^{adr_i[1:0], adr_i[31:ADDR_W+1]};

    // A phase starting on the accept edge must use the bus inputs, not the not-yet-latched copies.
    always_comb begin
        src_adr = accept ? adr_i[ADDR_W:2] : adr_q;
        src_dat = accept ? dat_i : dat_q;
        src_sel = accept ? sel_i : sel_q;
        src_we  = accept ? we_i  : we_q;
        ph_sel  = start_hi ? src_sel[3:2]  : src_sel[1:0];
        ph_dat  = start_hi ? src_dat[31:16] : src_dat[15:0];
    end

    sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (load),
        .last   (last),
        .we_win (we_win)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            ack_o        <= 1'b0;
            dat_o        <= '0;
            sram_addr_o  <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o  <= 1'b1;
            sram_oe_n_o  <= 1'b1;
            sram_we_n_o  <= 1'b1;
            sram_ub_n_o  <= 1'b1;
            sram_lb_n_o  <= 1'b1;
        end else begin
            ack_o <= 1'b0;

            if (load) begin
                sram_addr_o  <= {src_adr, start_hi};
                sram_ce_n_o  <= 1'b0;
                sram_oe_n_o  <= src_we;
                sram_we_n_o  <= ~src_we;
                sram_lb_n_o  <= ~ph_sel[0];
                sram_ub_n_o  <= ~ph_sel[1];
                sram_dq_oe_o <= src_we;
                if (src_we) begin
                    sram_dq_o <= ph_dat;
                end
            end else if (in_phase && last) begin
                sram_ce_n_o  <= 1'b1;
                sram_oe_n_o  <= 1'b1;
                sram_we_n_o  <= 1'b1;
                sram_ub_n_o  <= 1'b1;
                sram_lb_n_o  <= 1'b1;
                sram_dq_oe_o <= 1'b0;
            end else if (in_phase) begin
                sram_we_n_o <= ~(we_q && we_win);
            end

            case (state)
                IDLE: begin
                    if (stb_i) begin
                        adr_q <= adr_i[ADDR_W:2];
                        dat_q <= dat_i;
                        sel_q <= sel_i;
                        we_q  <= we_i;
                        dat_o <= '0;
                        if (start_lo) begin
                            state <= LO;
                        end else if (start_hi) begin
                            state <= HI;
                        end else begin
                            state <= DONE;
                            ack_o <= 1'b1;
                        end
                    end
                end
                LO: begin
                    if (last) begin
                        if (!we_q) begin
                            dat_o[15:0] <= sram_dq_i & lane_mask(sel_q[1:0]);
                        end
                        if (start_hi) begin
                            state <= HI;
                        end else begin
                            state <= DONE;
                            ack_o <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (last) begin
                        if (!we_q) begin
                            dat_o[31:16] <= sram_dq_i & lane_mask(sel_q[3:2]);
                        end
                        state <= DONE;
                        ack_o <= 1'b1;
                    end
                end
                DONE:    state <= RECOV;
                RECOV:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench: directed and random bus transfers against an SRAM model and a word-level reference.
module tb_wb_sram_ctrl;

    localparam int ADDR_W = 18;
    localparam int W      = 2;

    logic              clk = 1'b0;
    logic              rst, stb, we, ack;
    logic [31:0]       adr, dat_w, dat_r;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       dq_in, dq_out;
    logic              dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [int];
    logic [31:0] ref_mem  [int];

    int                ce_cnt, wel_cnt, oe_cnt, ack_cnt, bad_wr;
    logic [ADDR_W-1:0] addr_q [$];
    logic [1:0]        lane_q [$];
    logic [15:0]       dq_q   [$];
    logic              prev_ce;
    logic [ADDR_W-1:0] prev_addr;

    wb_sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stb_i        (stb),
        .we_i         (we),
        .adr_i        (adr),
        .dat_i        (dat_w),
        .sel_i        (sel),
        .dat_o        (dat_r),
        .ack_o        (ack),
        .sram_addr_o  (sram_addr),
        .sram_dq_i    (dq_in),
        .sram_dq_o    (dq_out),
        .sram_dq_oe_o (dq_oe),
        .sram_ce_n_o  (ce_n),
        .sram_oe_n_o  (oe_n),
        .sram_we_n_o  (we_n),
        .sram_ub_n_o  (ub_n),
        .sram_lb_n_o  (lb_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] sram_rd(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
    endfunction

    // Asynchronous SRAM: drives the full halfword whenever chip and output are enabled.
    always @* dq_in = (!ce_n && !oe_n) ? sram_rd(int'(sram_addr)) : 16'h0000;

    always @(posedge clk) begin
        logic [15:0] cur;
        if (!ce_n && !we_n) begin
            cur = sram_rd(int'(sram_addr));
            if (!lb_n) cur[7:0]  = dq_out[7:0];
            if (!ub_n) cur[15:8] = dq_out[15:8];
            sram_mem[int'(sram_addr)] = cur;
            if (!dq_oe) bad_wr++;
        end
    end

    always @(negedge clk) begin
        if (ack)   ack_cnt++;
        if (dq_oe) oe_cnt++;
        if (!ce_n) begin
            ce_cnt++;
            if (!we_n) wel_cnt++;
            if (prev_ce || sram_addr != prev_addr) begin
                addr_q.push_back(sram_addr);
                lane_q.push_back({ub_n, lb_n});
                if (dq_oe) dq_q.push_back(dq_out);
            end
        end
        prev_ce   = ce_n;
        prev_addr = sram_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int late, input string tag);
        int          k, idx;
        int          ph [$];
        logic [31:0] m, exp_rd, got_rd, cur;
        idx = int'((a >> 2) & ((32'd1 << (ADDR_W - 1)) - 1));
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
        if (|s[1:0]) ph.push_back(0);
        if (|s[3:2]) ph.push_back(1);

        @(negedge clk);
        ce_cnt = 0; wel_cnt = 0; oe_cnt = 0; ack_cnt = 0;
        addr_q.delete(); lane_q.delete(); dq_q.delete();
        stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!ack && k < 50) begin
            @(negedge clk);
            k++;
        end
        got_rd = dat_r;
        repeat (late) @(negedge clk);
        stb = 1'b0; we = 1'($urandom); adr = $urandom; dat_w = $urandom; sel = 4'($urandom);
        repeat (3) @(negedge clk);

        check({tag, "_lat"},  k,       ph.size() * W);
        check({tag, "_acks"}, ack_cnt, 1);
        check({tag, "_ce"},   ce_cnt,  ph.size() * W);
        check({tag, "_wel"},  wel_cnt, w ? ph.size() * (W - 1) : 0);
        check({tag, "_dqoe"}, oe_cnt,  w ? ph.size() * W : 0);
        check({tag, "_nph"},  addr_q.size(), ph.size());
        for (int i = 0; i < ph.size() && i < addr_q.size(); i++) begin
            check({tag, "_addr"}, addr_q[i], idx * 2 + ph[i]);
            check({tag, "_lanes"}, lane_q[i], {~s[2*ph[i]+1], ~s[2*ph[i]]});
            if (w && i < dq_q.size()) check({tag, "_dq"}, dq_q[i], d[16*ph[i] +: 16]);
        end
        cur = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
        if (w) begin
            check({tag, "_ndq"}, dq_q.size(), ph.size());
            check({tag, "_wdat"}, got_rd, 32'h0);
            ref_mem[idx] = (cur & ~m) | (d & m);
        end else begin
            exp_rd = cur & m;
            check({tag, "_rdat"}, got_rd, exp_rd);
            check({tag, "_hold"}, dat_r, exp_rd);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          idx;
        rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
        bad_wr = 0; prev_ce = 1'b1; prev_addr = '0;
        ce_cnt = 0; wel_cnt = 0; oe_cnt = 0; ack_cnt = 0;
        repeat (3) @(negedge clk);
        check("rst_pins", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, ack}, 7'b1111100);
        check("rst_dat",  dat_r,     32'h0);
        check("rst_addr", sram_addr, 32'h0);
        check("rst_dq",   dq_out,    32'h0);
        rst = 1'b0;

        xfer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 0, "wr_word");
        xfer(1'b0, 32'h0000_0100, 32'h0,         4'b1111, 0, "rd_word");
        xfer(1'b1, 32'h0000_0104, 32'h00AB_0000, 4'b0100, 0, "wr_byte");
        xfer(1'b0, 32'h0000_0104, 32'h0,         4'b1111, 0, "rd_byte");
        xfer(1'b0, 32'h0000_0100, 32'h0,         4'b1111, 0, "rd_again");
        xfer(1'b0, 32'h0000_0100, 32'h0,         4'b0000, 0, "sel0");
        xfer(1'b1, 32'h0000_0108, 32'h1234_5678, 4'b1111, 2, "late_stb");
        xfer(1'b0, 32'h0000_0108, 32'h0,         4'b0011, 2, "late_rd");

        // Abort a write in its first LO cycle, before any strobe edge reaches the SRAM.
        @(negedge clk);
        ack_cnt = 0; ce_cnt = 0;
        stb = 1'b1; we = 1'b1; adr = 32'h0000_010C; dat_w = 32'hCAFE_F00D; sel = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        check("abort_active", ce_n, 1'b0);
        #1 rst = 1'b1; stb = 1'b0;
        #1;
        check("abort_pins", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, ack}, 7'b1111100);
        check("abort_addr", sram_addr, 32'h0);
        check("abort_dat",  dat_r,     32'h0);
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0; ce_cnt = 0;
        repeat (5) @(negedge clk);
        check("abort_idle_ce",  ce_cnt,  0);
        check("abort_idle_ack", ack_cnt, 0);
        xfer(1'b0, 32'h0000_010C, 32'h0, 4'b1111, 0, "rd_abort");

        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, 15);
            a = $urandom;
            a[ADDR_W:2] = '0;
            a[5:2] = idx[3:0];
            xfer(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), "rnd");
        end

        check("wr_without_dq_oe", bad_wr, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
